// File: rtl/accelerator_scalar_function_arbiter_pkg.sv
// Shared types and constants for the scalar function arbiter family:
// FSM encoding, zero/one literals and the default watchdog limit.
package accelerator_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_WAIT    = 2'd1;
  localparam state_t S_RESPOND = 2'd2;

  localparam logic [63:0] CTRL_ZERO = 64'd0;
  localparam logic [63:0] CTRL_ONE  = 64'd1;
  localparam logic [63:0] DATA_ZERO = 64'd0;
  localparam logic [63:0] DATA_ONE  = 64'd1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/accelerator_scalar_function_arbiter_if.sv
// Client-side and shared-unit-side signals of the scalar function arbiter.
// slave = arbiter view, master = clients plus shared unit.
interface accelerator_scalar_function_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int DATA_SIZE  = 64
);
  logic [REQUESTERS-1:0]           REQ_VALID;
  logic [REQUESTERS*DATA_SIZE-1:0] REQ_DATA_IN;
  logic [REQUESTERS-1:0]           REQ_READY;
  logic                            REQ_ERROR;
  logic [DATA_SIZE-1:0]            DATA_OUT;
  logic                            BUSY;
  logic                            FU_START;
  logic [DATA_SIZE-1:0]            FU_DATA_IN;
  logic                            FU_READY;
  logic [DATA_SIZE-1:0]            FU_DATA_OUT;

  modport slave (
    input  REQ_VALID, REQ_DATA_IN, FU_READY, FU_DATA_OUT,
    output REQ_READY, REQ_ERROR, DATA_OUT, BUSY, FU_START, FU_DATA_IN
  );

  modport master (
    output REQ_VALID, REQ_DATA_IN, FU_READY, FU_DATA_OUT,
    input  REQ_READY, REQ_ERROR, DATA_OUT, BUSY, FU_START, FU_DATA_IN
  );
endinterface

// File: rtl/accelerator_round_robin_picker.sv
// Combinational rotate-priority encoder: first set request at or after ptr,
// wrapping modulo REQUESTERS.
module accelerator_round_robin_picker #(
  parameter  int REQUESTERS = 4,
  localparam int IW         = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [IW-1:0]         ptr,
  output logic                  found,
  output logic [IW-1:0]         idx
);
  logic [IW:0] cand;

  // Scan from the farthest slot back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(REQUESTERS)) cand = cand - (IW+1)'(REQUESTERS);
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/accelerator_scalar_function_arbiter.sv
// Round-robin sharing of one START/READY scalar unit among REQUESTERS clients.
// Optional watchdog: define ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN.
module accelerator_scalar_function_arbiter
  import accelerator_arbiter_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int CONTROL_SIZE   = 64,
  parameter int REQUESTERS     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic CLK,
  input logic RST,
  accelerator_scalar_function_arbiter_if.slave bus
);
  localparam int IW = $clog2(REQUESTERS);

  if (REQUESTERS < 2 || REQUESTERS > 16 || CONTROL_SIZE < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("accelerator_scalar_function_arbiter: unsupported parameter set");
  end

  state_t                state;
  logic [IW-1:0]         grant, ptr, pick_idx;
  logic                  pick_found;
  logic [REQUESTERS-1:0] req_ready;
  logic [DATA_SIZE-1:0]  data_out, fu_data_in;
  logic                  fu_start;
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
  logic                    req_error;
  logic [CONTROL_SIZE-1:0] wait_cnt;
`endif

  accelerator_round_robin_picker #(.REQUESTERS(REQUESTERS)) u_pick (
    .req   (bus.REQ_VALID),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      grant      <= '0;
      ptr        <= '0;
      req_ready  <= '0;
      data_out   <= DATA_SIZE'(DATA_ZERO);
      fu_start   <= 1'b0;
      fu_data_in <= DATA_SIZE'(DATA_ZERO);
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
      req_error  <= 1'b0;
      wait_cnt   <= CONTROL_SIZE'(CTRL_ZERO);
`endif
    end else begin
      case (state)
        S_IDLE: if (pick_found) begin
          grant      <= pick_idx;
          fu_data_in <= bus.REQ_DATA_IN[int'(pick_idx)*DATA_SIZE +: DATA_SIZE];
          fu_start   <= 1'b1;
          state      <= S_WAIT;
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
          wait_cnt   <= CONTROL_SIZE'(CTRL_ZERO);
`endif
        end
        S_WAIT: begin
          fu_start <= 1'b0;
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
          wait_cnt <= wait_cnt + CONTROL_SIZE'(CTRL_ONE);
`endif
          // fu_start marks the first WAIT cycle, where a stale FU_READY is ignored.
          if (!fu_start && bus.FU_READY) begin
            data_out  <= bus.FU_DATA_OUT;
            req_ready <= REQUESTERS'(1) << grant;
            state     <= S_RESPOND;
          end
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
          else if (wait_cnt == CONTROL_SIZE'(TIMEOUT_CYCLES - 1)) begin
            data_out  <= DATA_SIZE'(DATA_ZERO);
            req_ready <= REQUESTERS'(1) << grant;
            req_error <= 1'b1;
            state     <= S_RESPOND;
          end
`endif
        end
        S_RESPOND: begin
          req_ready <= '0;
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
          req_error <= 1'b0;
`endif
          ptr   <= (grant == IW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.DATA_OUT   = data_out;
  assign bus.BUSY       = (state != S_IDLE);
  assign bus.FU_START   = fu_start;
  assign bus.FU_DATA_IN = fu_data_in;
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
  assign bus.REQ_ERROR  = req_error;
`else
  assign bus.REQ_ERROR  = 1'b0;
`endif
endmodule

// File: tb/tb_accelerator_scalar_function_arbiter.sv
// Scoreboard bench for accelerator_scalar_function_arbiter; the timeout scenario
// follows ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN.
module tb_accelerator_scalar_function_arbiter;
  localparam int R  = 4;
  localparam int DS = 64;
  localparam int TO = 8;

  typedef struct packed {
    logic [R-1:0]  rdy;
    logic [DS-1:0] data;
    logic          err;
  } rsp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  accelerator_scalar_function_arbiter_if #(.REQUESTERS(R), .DATA_SIZE(DS)) bus ();

  accelerator_scalar_function_arbiter #(
    .DATA_SIZE(DS), .CONTROL_SIZE(16), .REQUESTERS(R), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [R-1:0]    req_valid = '0;
  logic [R*DS-1:0] req_data  = '0;
  int              fu_mode   = 0;   // 0: ready after fu_delay, 1: ready held high, 2: never ready
  int              fu_delay  = 3;
  int              fu_cnt;
  logic            fu_rdy_r;

  assign bus.REQ_VALID   = req_valid;
  assign bus.REQ_DATA_IN = req_data;
  assign bus.FU_READY    = (fu_mode == 1) ? 1'b1 : fu_rdy_r;
  assign bus.FU_DATA_OUT = bus.FU_DATA_IN + 64'd1;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      fu_rdy_r <= 1'b0;
      fu_cnt   <= 0;
    end else begin
      fu_rdy_r <= 1'b0;
      if (bus.FU_START && fu_mode == 0) fu_cnt <= fu_delay;
      else if (fu_cnt > 0) begin
        fu_cnt <= fu_cnt - 1;
        if (fu_cnt == 1) fu_rdy_r <= 1'b1;
      end
    end
  end

  int   vectors = 0, miscompares = 0;
  int   cyc = 0, fu_starts = 0, start_cyc, rdy_cyc, drive_cyc;
  int   pend [R];
  rsp_t exp_q[$];

  // Advance on negedges; each REQ_READY pulse is popped against the scoreboard.
  task automatic run(input string tag, input int n, input int budget, input bit must);
    int   got = 0;
    int   k = 0;
    rsp_t o, e;
    start_cyc = -1;
    rdy_cyc   = -1;
    while (got < n && k < budget) begin
      @(negedge CLK);
      k++;
      cyc++;
      if (bus.FU_START) begin
        fu_starts++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (bus.REQ_READY != '0) begin
        got++;
        if (rdy_cyc < 0) rdy_cyc = cyc;
        o = {bus.REQ_READY, bus.DATA_OUT, bus.REQ_ERROR};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s: unexpected pulse rdy=%b data=%h err=%b, required none", tag, o.rdy, o.data, o.err);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b data=%h err=%b, required rdy=%b data=%h err=%b",
                     tag, o.rdy, o.data, o.err, e.rdy, e.data, e.err);
          end
        end
        for (int i = 0; i < R; i++)
          if (bus.REQ_READY[i] && pend[i] > 0) begin
            pend[i]--;
            if (pend[i] == 0) req_valid[i] = 1'b0;
          end
      end
    end
    if (must && got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait: got %0d pulses, required %0d within %0d cycles", tag, got, n, budget);
    end
  endtask

  task automatic set_req(input int c, input logic [DS-1:0] op, input int count);
    req_data[c*DS +: DS] = op;
    req_valid[c]         = 1'b1;
    pend[c]              = count;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if ({bus.REQ_READY, bus.REQ_ERROR, bus.DATA_OUT, bus.BUSY} !== '0) begin
      miscompares++;
      $display("FAIL reset_client_side: got rdy=%b err=%b data=%h busy=%b, required all 0",
               bus.REQ_READY, bus.REQ_ERROR, bus.DATA_OUT, bus.BUSY);
    end
    vectors++;
    if ({bus.FU_START, bus.FU_DATA_IN} !== '0) begin
      miscompares++;
      $display("FAIL reset_fu_side: got start=%b din=%h, required 0", bus.FU_START, bus.FU_DATA_IN);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_client();
    fu_mode   = 0;
    fu_delay  = 5;
    fu_starts = 0;
    set_req(2, 64'h10, 1);
    drive_cyc = cyc;
    exp_q.push_back({4'b0100, 64'h11, 1'b0});
    run("single", 1, 40, 1);
    vectors++;
    if (start_cyc !== drive_cyc + 1) begin
      miscompares++;
      $display("FAIL single_start_latency: got cycle %0d, required %0d", start_cyc, drive_cyc + 1);
    end
    run("single_settle", 1000, 4, 0);
    vectors++;
    if (fu_starts !== 1) begin
      miscompares++;
      $display("FAIL single_start_count: got %0d, required 1", fu_starts);
    end
    vectors++;
    if (bus.BUSY !== 1'b0 || bus.DATA_OUT !== 64'h11) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b data=%h, required busy=0 data=11", bus.BUSY, bus.DATA_OUT);
    end
  endtask

  task automatic test_pointer_wrap();
    fu_delay = 2;
    set_req(3, 64'h30, 1);
    exp_q.push_back({4'b1000, 64'h31, 1'b0});
    run("wrap_first", 1, 40, 1);
    run("wrap_settle", 1000, 3, 0);
    set_req(0, 64'h20, 1);
    set_req(3, 64'h30, 1);
    exp_q.push_back({4'b0001, 64'h21, 1'b0});
    exp_q.push_back({4'b1000, 64'h31, 1'b0});
    run("wrap", 2, 60, 1);
    run("wrap_settle", 1000, 4, 0);
  endtask

  task automatic test_fairness();
    fu_delay = 3;
    for (int i = 0; i < R; i++) set_req(i, 64'h100 + 64'(i), (i == 0) ? 2 : 1);
    for (int k = 0; k < 5; k++) begin
      logic [R-1:0] oh;
      oh = '0;
      oh[k % R] = 1'b1;
      exp_q.push_back({oh, 64'h101 + 64'(k % R), 1'b0});
    end
    run("fairness", 5, 200, 1);
    run("fairness_settle", 1000, 4, 0);
  endtask

  task automatic test_early_ready();
    fu_mode   = 1;
    fu_starts = 0;
    set_req(1, 64'h55, 1);
    exp_q.push_back({4'b0010, 64'h56, 1'b0});
    run("early", 1, 20, 1);
    vectors++;
    if (rdy_cyc - start_cyc !== 2) begin
      miscompares++;
      $display("FAIL early_latency: got %0d cycles start->ready, required 2", rdy_cyc - start_cyc);
    end
    run("early_settle", 1000, 4, 0);
    vectors++;
    if (fu_starts !== 1) begin
      miscompares++;
      $display("FAIL early_start_count: got %0d, required 1", fu_starts);
    end
    fu_mode = 0;
  endtask

  task automatic test_back_to_back();
    fu_delay  = 1;
    fu_starts = 0;
    set_req(2, 64'h77, 3);
    for (int k = 0; k < 3; k++) exp_q.push_back({4'b0100, 64'h78, 1'b0});
    run("b2b", 3, 60, 1);
    run("b2b_settle", 1000, 4, 0);
    vectors++;
    if (fu_starts !== 3) begin
      miscompares++;
      $display("FAIL b2b_start_count: got %0d, required 3", fu_starts);
    end
  endtask

  task automatic test_reset_mid_wait();
    fu_mode = 2;
    set_req(1, 64'h91, 1);
    set_req(3, 64'h93, 1);
    run("rst_pre", 1000, 5, 0);
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.FU_DATA_IN !== 64'h93) begin
      miscompares++;
      $display("FAIL rst_pre_wait: got busy=%b din=%h, required busy=1 din=93", bus.BUSY, bus.FU_DATA_IN);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({bus.REQ_READY, bus.REQ_ERROR, bus.DATA_OUT, bus.BUSY, bus.FU_START, bus.FU_DATA_IN} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got rdy=%b err=%b data=%h busy=%b start=%b din=%h, required all 0",
               bus.REQ_READY, bus.REQ_ERROR, bus.DATA_OUT, bus.BUSY, bus.FU_START, bus.FU_DATA_IN);
    end
    @(negedge CLK);
    RST      = 1'b0;
    fu_mode  = 0;
    fu_delay = 2;
    exp_q.push_back({4'b0010, 64'h92, 1'b0});
    exp_q.push_back({4'b1000, 64'h94, 1'b0});
    run("rst_post", 2, 60, 1);
    run("rst_settle", 1000, 4, 0);
  endtask

  task automatic test_timeout();
`ifdef ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN
    fu_mode = 2;
    set_req(0, 64'hAA, 1);
    exp_q.push_back({4'b0001, 64'h0, 1'b1});
    run("timeout", 1, 40, 1);
    vectors++;
    if (rdy_cyc - start_cyc !== TO) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d, required %0d", rdy_cyc - start_cyc, TO);
    end
    run("timeout_settle", 1000, 4, 0);
    vectors++;
    if (bus.REQ_ERROR !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err_clear: got %b, required 0", bus.REQ_ERROR);
    end
    fu_mode  = 0;
    fu_delay = 6;
    set_req(1, 64'hBB, 1);
    exp_q.push_back({4'b0010, 64'hBC, 1'b0});
    run("timeout_race", 1, 40, 1);
    vectors++;
    if (rdy_cyc - start_cyc !== TO) begin
      miscompares++;
      $display("FAIL timeout_race_latency: got %0d, required %0d", rdy_cyc - start_cyc, TO);
    end
    run("timeout_race_settle", 1000, 4, 0);
`else
    fu_mode = 2;
    set_req(0, 64'hAA, 1);
    run("no_timeout", 1000, 5 * TO, 0);
    vectors++;
    if (bus.BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL no_timeout_busy: got %b, required 1", bus.BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST       = 1'b0;
    req_valid = '0;
    pend[0]   = 0;
    fu_mode   = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_client();
    test_pointer_wrap();
    test_fairness();
    test_early_ready();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL missing_responses: %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/accelerator_scalar_function_arbiter.md
Name: accelerator_scalar_function_arbiter

Overview:
- Shares one scalar series unit (e.g. scalar cosh/sinh/exponentiator, START/READY/DATA_IN/DATA_OUT handshake) between REQUESTERS independent clients, typically several vector/matrix sequencers.
- Round-robin arbitration; one operation in flight at a time.
- Result and a one-hot completion pulse are returned to the granted client.

Parameters:
- DATA_SIZE, 64, operand/result width.
- CONTROL_SIZE, 64, width of internal counters.
- REQUESTERS, 4, number of clients (2..16).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- REQ_VALID  in  REQUESTERS  per-client request level.
- REQ_DATA_IN  in  REQUESTERS*DATA_SIZE  packed operands; client i uses slice [i*DATA_SIZE +: DATA_SIZE].
- REQ_READY  out  REQUESTERS  one-hot, one-cycle completion pulse.
- REQ_ERROR  out  1  timeout flag, qualified by REQ_READY.
- DATA_OUT  out  DATA_SIZE  result for the client pulsed on REQ_READY.
- BUSY  out  1  high whenever state is not IDLE.
- FU_START  out  1  start pulse to the shared unit.
- FU_DATA_IN  out  DATA_SIZE  operand to the shared unit.
- FU_READY  in  1  done from the shared unit.
- FU_DATA_OUT  in  DATA_SIZE  result from the shared unit.

Behaviour:
- Reset values: REQ_READY=0, REQ_ERROR=0, DATA_OUT=0, BUSY=0, FU_START=0, FU_DATA_IN=0, grant index=0, priority pointer=0 (client 0 has highest priority), state=IDLE. Reset applied mid-operation aborts the operation; no REQ_READY pulse follows. The shared unit shares RST.
- State IDLE:
  - If any REQ_VALID bit is set, pick the first set bit starting at the pointer and wrapping modulo REQUESTERS.
  - Register the grant index and FU_DATA_IN <= that client's operand.
  - Set FU_START <= 1 and go to WAIT.
  - With no request, remain in IDLE.
- State WAIT:
  - FU_START is high only in the first WAIT cycle, then cleared.
  - FU_READY is ignored in that first cycle; it is sampled from the second WAIT cycle onward.
  - When FU_READY=1: DATA_OUT <= FU_DATA_OUT, REQ_READY[grant] <= 1, go to RESPOND.
- State RESPOND:
  - REQ_READY and REQ_ERROR are high for exactly this one cycle.
  - Pointer <= (grant+1) mod REQUESTERS.
  - Go to IDLE.
- Latency: REQ_VALID sampled at edge t; FU_START is high in cycle t+1. FU_READY sampled at edge r gives REQ_READY high in cycle r+1. The next grant is sampled at edge r+2.
- Handshake rules:
  - A client holds REQ_VALID and its operand stable until its REQ_READY pulse.
  - A client deasserts REQ_VALID in the cycle its REQ_READY pulse is high; otherwise it is treated as a new request.
  - If REQ_VALID drops after the grant, the result is still delivered to the granted index.
- Requests arriving during WAIT/RESPOND are queued only by their level; no request is lost while held.
- DATA_OUT holds its last value between pulses.
- Starvation bound: any held request is served within REQUESTERS operations.
- A single requester back-to-back is re-granted every operation.

Optional Feature:
- Macro: ACCELERATOR_SCALAR_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - A CONTROL_SIZE counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no FU_READY, go to RESPOND with REQ_READY[grant]=1, REQ_ERROR=1, DATA_OUT=0.
  - FU_READY arriving in the same cycle as the limit wins: normal result, REQ_ERROR=0.
- Without the macro: no counter is built, REQ_ERROR is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package accelerator_arbiter_pkg holds:
  - the state encoding IDLE/WAIT/RESPOND as a 2-bit typedef;
  - ZERO/ONE control and data constants;
  - the default TIMEOUT_CYCLES.
- Sub-module accelerator_round_robin_picker: combinational rotate-priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: found flag, grant index.
  - It is reused by future vector/matrix arbiters.

Test Plan:
- Single client: REQUESTERS=4, client 2 operand 0x10, FU model returns operand+1 after 5 cycles -> one FU_START pulse; REQ_READY=4'b0100 for one cycle; DATA_OUT=0x11; BUSY low afterwards.
- Fairness: all 4 clients held valid continuously -> grant order 0,1,2,3,0; each REQ_READY bit pulses once per 4 operations; every DATA_OUT matches the granted client's operand+1.
- Pointer wrap: after serving client 3, only clients 0 and 3 valid -> client 0 is granted first, then client 3.
- Early FU_READY: FU_READY held high from the FU_START cycle -> it is ignored in that cycle; completion is taken on the next cycle; exactly one REQ_READY pulse.
- Reset mid-WAIT: RST pulsed during WAIT -> all outputs return to reset values immediately (asynchronously); no REQ_READY pulse; the next request is granted from pointer 0.
- Timeout (macro on, TIMEOUT_CYCLES=8): FU never asserts FU_READY -> REQ_READY pulse with REQ_ERROR=1 and DATA_OUT=0 after 8 WAIT cycles. With the macro off, BUSY stays high indefinitely.
